// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   (requester 0, fixed priority) and the multi-cycle MUL/DIV/FPU result
//   streams (requesters 1..N_REQ-1, round-robin with anti-starvation).
//   The grant is a combinational one-cycle ready. The granted write reaches the
//   reg_file one cycle later through registered outputs.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   req_valid      in   [N_REQ]         requester i has a result pending
//   req_ready      out  [N_REQ]         one-hot grant (zero when nothing granted)
//   req_addr       in   [N_REQ*ADDR_W]  rd address, slice i = [i*ADDR_W +: ADDR_W]
//   req_data       in   [N_REQ*DATA_W]  rd data,    slice i = [i*DATA_W +: DATA_W]
//   rd_wena_to_WB  out  registered write enable (0 for writes to x0)
//   rd_addr_to_WB  out  registered write address
//   rd_data_to_WB  out  registered write data
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int STARVE_MAX = 7,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      rd_wena_to_WB,
  output logic [ADDR_W-1:0]         rd_addr_to_WB,
  output logic [DATA_W-1:0]         rd_data_to_WB
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]     rr_ptr_r;
  logic [CW-1:0]     wait_cnt_r [1:N_REQ-1];

  logic              urg_found_s;
  logic [PW-1:0]     urg_idx_s;
  logic              rr_found_s;
  logic [PW-1:0]     rr_idx_s;
  logic              grant_any_s;
  logic [PW-1:0]     grant_idx_s;
  logic [N_REQ-1:0]  grant_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  // k-th position of the round-robin ring starting at ptr; the ring holds
  // only indices 1..N_REQ-1, so N_REQ-1 wraps back to 1.
  function automatic logic [PW-1:0] ring_idx(input logic [PW-1:0] ptr, input int k);
    int t;
    t = int'(ptr) - 1 + k;
    if (t >= N_REQ - 1) begin
      t = t - (N_REQ - 1);
    end else begin
      t = t;
    end
    return PW'(t + 1);
  endfunction

  // Ring search for the first urgent and the first merely valid requester.
  always_comb begin
    urg_found_s = 1'b0;
    urg_idx_s   = '0;
    rr_found_s  = 1'b0;
    rr_idx_s    = '0;
    for (int k = 0; k < N_REQ - 1; k++) begin
      if (!urg_found_s && req_valid[ring_idx(rr_ptr_r, k)] &&
          (wait_cnt_r[ring_idx(rr_ptr_r, k)] == CW'(STARVE_MAX))) begin
        urg_found_s = 1'b1;
        urg_idx_s   = ring_idx(rr_ptr_r, k);
      end else begin
        urg_found_s = urg_found_s;
      end
      if (!rr_found_s && req_valid[ring_idx(rr_ptr_r, k)]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = ring_idx(rr_ptr_r, k);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Priority: urgent stream, then the pipe, then plain round-robin.
  // No grant at all while reset is held.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    if (reset) begin
      grant_any_s = 1'b0;
    end else if (urg_found_s) begin
      grant_any_s = 1'b1;
      grant_idx_s = urg_idx_s;
    end else if (req_valid[0]) begin
      grant_any_s = 1'b1;
      grant_idx_s = '0;
    end else if (rr_found_s) begin
      grant_any_s = 1'b1;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // One-hot ready and mux of the granted requester's payload.
  always_comb begin
    grant_s    = '0;
    sel_addr_s = req_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
    sel_data_s = req_data[int'(grant_idx_s)*DATA_W +: DATA_W];
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready = grant_s;

  // Registered write port: single-cycle pulse per grant, x0 writes suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_wena_to_WB <= 1'b0;
      rd_addr_to_WB <= '0;
      rd_data_to_WB <= '0;
    end else if (grant_any_s) begin
      rd_wena_to_WB <= (sel_addr_s != '0);
      rd_addr_to_WB <= sel_addr_s;
      rd_data_to_WB <= sel_data_s;
    end else begin
      rd_wena_to_WB <= 1'b0;
      rd_addr_to_WB <= '0;
      rd_data_to_WB <= '0;
    end
  end

  // Round-robin pointer moves past a granted stream; pipe grants leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= PW'(1);
    end else if (grant_any_s && (grant_idx_s != '0)) begin
      rr_ptr_r <= (grant_idx_s == PW'(N_REQ - 1)) ? PW'(1) : grant_idx_s + PW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Per-stream wait counters, saturating at STARVE_MAX (the urgency threshold).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < N_REQ; i++) begin
        wait_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < N_REQ; i++) begin
        if (req_valid[i] && !grant_s[i]) begin
          wait_cnt_r[i] <= (wait_cnt_r[i] == CW'(STARVE_MAX)) ? wait_cnt_r[i]
                                                             : wait_cnt_r[i] + CW'(1);
        end else begin
          wait_cnt_r[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed scenarios plus a randomized run checked against a behavioural
//   model of the grant rules and a write-order scoreboard.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int N  = 4;
  localparam int SM = 7;
  localparam int AW = 6;
  localparam int DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            rd_wena_to_WB;
  logic [AW-1:0]   rd_addr_to_WB;
  logic [DW-1:0]   rd_data_to_WB;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Current request payloads as driven.
  logic [AW-1:0] cur_a [N];
  logic [DW-1:0] cur_d [N];

  // Behavioural model state.
  int            m_wait [N];
  int            m_rr;
  logic          nx_wena;
  logic [AW-1:0] nx_addr;
  logic [DW-1:0] nx_data;

  wb_port_arbiter #(.N_REQ(N), .STARVE_MAX(SM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rd_wena_to_WB(rd_wena_to_WB),
    .rd_addr_to_WB(rd_addr_to_WB), .rd_data_to_WB(rd_data_to_WB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
    cur_a[i]              = a;
    cur_d[i]              = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_rr = 1;
    nx_wena = 1'b0; nx_addr = '0; nx_data = '0;
  endtask

  // Reset held for two edges, released at a falling edge.
  task automatic apply_reset();
    reset = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Expected grant index from the rules, -1 for none.
  function automatic int model_grant(input logic [N-1:0] v);
    int idx;
    for (int k = 0; k < N - 1; k++) begin
      idx = 1 + ((m_rr - 1 + k) % (N - 1));
      if (v[idx] && m_wait[idx] >= SM) return idx;
    end
    if (v[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      idx = 1 + ((m_rr - 1 + k) % (N - 1));
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_commit(input logic [N-1:0] v, input int g);
    for (int i = 1; i < N; i++) begin
      if (v[i] && g != i) m_wait[i] = (m_wait[i] + 1 > SM) ? SM : m_wait[i] + 1;
      else                m_wait[i] = 0;
    end
    if (g >= 1) m_rr = (g == N - 1) ? 1 : g + 1;
    if (g >= 0) begin
      nx_wena = (cur_a[g] != '0); nx_addr = cur_a[g]; nx_data = cur_d[g];
    end else begin
      nx_wena = 1'b0; nx_addr = '0; nx_data = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(i));
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== '0)
      $display("FAIL reset_outputs: got %b/%0h/%0h expected 0/0/0", rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
    else pass_cnt++;
    apply_reset();
    @(posedge clk); #1;
    total_cnt++;
    if (rd_wena_to_WB !== 1'b0) $display("FAIL idle_wena: got %b expected 0", rd_wena_to_WB);
    else pass_cnt++;
  endtask

  task automatic test_single();
    apply_reset();
    set_req(1, 1'b1, 6'd5, 32'hDEADBEEF);
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, '0);
    total_cnt++;
    if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {1'b1, 6'd5, 32'hDEADBEEF})
      $display("FAIL single_write: got %b/%0h/%0h expected 1/5/deadbeef", rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== '0)
      $display("FAIL single_pulse: got %b/%0h/%0h expected 0/0/0", rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    logic [N-1:0] exp_r;
    apply_reset();
    set_req(0, 1'b1, 6'd1, 32'h11);
    set_req(2, 1'b1, 6'd2, 32'h22);
    for (int c = 0; c < 16; c++) begin
      #1;
      exp_r = (c == 7 || c == 15) ? 4'b0100 : 4'b0001;
      total_cnt++;
      if (req_ready !== exp_r) $display("FAIL starve_c%0d: got %b expected %b", c, req_ready, exp_r);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_r;
    apply_reset();
    for (int i = 1; i < N; i++) set_req(i, 1'b1, AW'(i + 8), DW'(i));
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_r = 4'b0001 << (1 + (c % 3));
      total_cnt++;
      if (req_ready !== exp_r) $display("FAIL rr_c%0d: got %b expected %b", c, req_ready, exp_r);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_x0();
    apply_reset();
    set_req(3, 1'b1, 6'd0, 32'h1234);
    #1;
    total_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL x0_ready: got %b expected 1000", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    set_req(3, 1'b1, 6'd32, 32'h1234);
    total_cnt++;
    if ({rd_wena_to_WB, rd_addr_to_WB} !== {1'b0, 6'd0}) $display("FAIL x0_wena: got %b/%0h expected 0/0", rd_wena_to_WB, rd_addr_to_WB);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL f0_ready: got %b expected 1000", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    set_req(3, 1'b0, '0, '0);
    total_cnt++;
    if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {1'b1, 6'd32, 32'h1234})
      $display("FAIL f0_write: got %b/%0h/%0h expected 1/20/1234", rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
    else pass_cnt++;
  endtask

  task automatic test_reset_midcycle();
    apply_reset();
    set_req(1, 1'b1, 6'd9, 32'hCAFEF00D);
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL mid_ready: got %b expected 0010", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, '0);
    total_cnt++;
    if (rd_wena_to_WB !== 1'b1) $display("FAIL mid_write: got %b expected 1", rd_wena_to_WB);
    else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== '0)
      $display("FAIL mid_async_clear: got %b/%0h/%0h expected 0/0/0", rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rd_wena_to_WB !== 1'b0) $display("FAIL mid_no_write: got %b expected 0", rd_wena_to_WB);
    else pass_cnt++;
    for (int i = 1; i < N; i++) set_req(i, 1'b1, AW'(i + 16), DW'(i + 100));
    #1;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL mid_rr_restart: got %b expected 0010", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {1'b1, 6'd17, 32'd101})
      $display("FAIL mid_post_write: got %b/%0h/%0h expected 1/11/65", rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
    else pass_cnt++;
    clear_reqs();
  endtask

  task automatic test_random();
    logic [N-1:0]  v;
    logic [N-1:0]  exp_r;
    int            g;
    int            age [N];
    logic [AW+DW-1:0] sb [$];
    logic [AW+DW-1:0] head;
    logic [AW-1:0] na;
    apply_reset();
    for (int i = 0; i < N; i++) age[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, (i == 0) ? 2 : 3) == 0) begin
          na = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          set_req(i, 1'b1, na, DW'($urandom));
        end
      end
      #1;
      v = req_valid;
      g = model_grant(v);
      exp_r = (g < 0) ? '0 : (4'b0001 << g);
      total_cnt++;
      if (req_ready !== exp_r) $display("FAIL rand_ready@%0d: got %b expected %b", cyc, req_ready, exp_r);
      else pass_cnt++;
      total_cnt++;
      if (!$onehot0(req_ready) || ((req_ready & ~v) != '0))
        $display("FAIL rand_onehot@%0d: got ready %b valid %b expected onehot0 subset", cyc, req_ready, v);
      else pass_cnt++;
      if (g >= 0 && cur_a[g] != '0) sb.push_back({cur_a[g], cur_d[g]});
      model_commit(v, g);
      @(posedge clk); #1;
      total_cnt++;
      if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {nx_wena, nx_addr, nx_data})
        $display("FAIL rand_out@%0d: got %b/%0h/%0h expected %b/%0h/%0h", cyc,
                 rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB, nx_wena, nx_addr, nx_data);
      else pass_cnt++;
      if (rd_wena_to_WB === 1'b1) begin
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL rand_sb_extra@%0d: got write %0h expected none", cyc, rd_addr_to_WB);
        end else begin
          head = sb.pop_front();
          if ({rd_addr_to_WB, rd_data_to_WB} !== head)
            $display("FAIL rand_sb_order@%0d: got %0h expected %0h", cyc, {rd_addr_to_WB, rd_data_to_WB}, head);
          else pass_cnt++;
        end
      end
      for (int i = 1; i < N; i++) begin
        if (v[i] && g != i) age[i]++;
        else age[i] = 0;
        if (v[i]) begin
          total_cnt++;
          if (age[i] > SM + N - 1) $display("FAIL rand_starve@%0d: req %0d waited %0d expected <= %0d", cyc, i, age[i], SM + N - 1);
          else pass_cnt++;
        end
      end
      if (g >= 0) set_req(g, 1'b0, '0, '0);
    end
    total_cnt++;
    if (sb.size() != 0) $display("FAIL rand_sb_left: got %0d pending expected 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_starvation();
    test_round_robin();
    test_x0();
    test_reset_midcycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
